// File: rtl/pipe_pkg.sv
// Shared encodings for the execute stage: ALU ops, forwarding selects,
// mul/div ops and the mul/div FSM state values.
package pipe_pkg;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_XOR = 5'd4;
  localparam logic [4:0] ALU_LUI = 5'd5;
  localparam logic [4:0] ALU_SLL = 5'd6;
  localparam logic [4:0] ALU_SRL = 5'd7;
  localparam logic [4:0] ALU_SRA = 5'd8;

  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_IMM  = 2'b01;
  localparam logic [1:0] FWD_MALU = 2'b10;
  localparam logic [1:0] FWD_WDI  = 2'b11;

  localparam logic [1:0] MD_MULLO = 2'b00;
  localparam logic [1:0] MD_MULHI = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_REMU  = 2'b11;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_BUSY = 2'd1;
  localparam logic [1:0] MD_DONE = 2'd2;

  // Divide ops share the upper op bit; op[0] picks the high product half.
  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/md_iter.sv
// Iterative unsigned multiply / divide, one bit per cycle.
// Multiply: right-shifting shift-add, product = {upper, multiplier}.
// Divide: restoring, register = {remainder, quotient}. A zero divisor
// always "subtracts", giving quotient all-ones and remainder = dividend.
module md_iter
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      state
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [1:0]        state_q;
  logic [CW-1:0]     cnt;
  logic [1:0]        op_q;
  logic [XLEN-1:0]   b_q;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_nxt;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   rem_low;
  logic              rem_ge;

  // One iteration of the shift-add or restoring step.
  always_comb begin
    mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, b_q};
    rem_sh   = prod[2*XLEN-1:XLEN-1];
    rem_ge   = (rem_sh >= {1'b0, b_q});
    rem_low  = rem_sh[XLEN-1:0] - b_q;
    prod_nxt = prod;
    if (md_is_div(op_q)) begin
      if (rem_ge) prod_nxt = {rem_low, prod[XLEN-2:0], 1'b1};
      else        prod_nxt = {rem_sh[XLEN-1:0], prod[XLEN-2:0], 1'b0};
    end else if (prod[0]) begin
      prod_nxt = {mul_sum, prod[XLEN-1:1]};
    end else begin
      prod_nxt = {1'b0, prod[2*XLEN-1:1]};
    end
  end

  // FSM, operand capture and iteration counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt     <= '0;
      op_q    <= MD_MULLO;
      b_q     <= '0;
      prod    <= '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start && !flush) begin
            state_q <= MD_BUSY;
            cnt     <= '0;
            op_q    <= op;
            b_q     <= b;
            prod    <= {{XLEN{1'b0}}, a};
          end
        end
        MD_BUSY: begin
          if (flush) begin
            state_q <= MD_IDLE;
          end else begin
            prod <= prod_nxt;
            cnt  <= cnt + CW'(1);
            if (cnt == CW'(XLEN - 1)) state_q <= MD_DONE;
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy   = (state_q == MD_BUSY);
  assign done   = (state_q == MD_DONE);
  assign state  = state_q;
  assign result = op_q[0] ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];

endmodule

// File: rtl/pipeexe_md.sv
// Execute stage: forwarding muxes, ALU, jal link address, branch/jump
// resolution and an optional iterative mul/div unit.
// Handshake: the EX instruction is live when ex_valid=1; it leaves EX at a
// rising edge where estall=0. While estall=1 the upstream stages hold and no
// redirect is raised. eflush kills the instruction in the same cycle.
module pipeexe_md
  import pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int REGW  = 5,
  parameter int ALUCW = 5,
  parameter int MD_EN = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             eflush,
  input  logic [XLEN-1:0]  ea,
  input  logic [XLEN-1:0]  eb,
  input  logic [XLEN-1:0]  eimm,
  input  logic [XLEN-1:0]  epc4,
  input  logic [REGW-1:0]  ern0,
  input  logic [ALUCW-1:0] ealuc,
  input  logic [1:0]       eadepen,
  input  logic [1:0]       ebdepen,
  input  logic [XLEN-1:0]  malu,
  input  logic [XLEN-1:0]  wdi,
  input  logic             ejal,
  input  logic             ej,
  input  logic             ebeq,
  input  logic             ebne,
  input  logic             emd_en,
  input  logic [1:0]       emd_op,
  output logic [XLEN-1:0]  ealu,
  output logic [REGW-1:0]  ern,
  output logic             z,
  output logic             ex_is_uncond,
  output logic             ex_is_cond,
  output logic             estall
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] sa;
  logic [XLEN-1:0] alua;
  logic [XLEN-1:0] alub;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] epc8;
  logic [XLEN-1:0] md_result;
  logic            md_done;
  logic            md_start;

  assign sa       = {{(XLEN-5){1'b0}}, eimm[4:0]};
  assign epc8     = epc4 + XLEN'(4);
  assign md_start = ex_valid & emd_en;

  // Operand forwarding selects.
  always_comb begin
    case (eadepen)
      FWD_REG:  alua = ea;
      FWD_IMM:  alua = sa;
      FWD_MALU: alua = malu;
      default:  alua = wdi;
    endcase
    case (ebdepen)
      FWD_REG:  alub = eb;
      FWD_IMM:  alub = eimm;
      FWD_MALU: alub = malu;
      default:  alub = wdi;
    endcase
  end

  // Combinational ALU; shifts move alub by alua's low bits.
  always_comb begin
    case (ealuc)
      ALU_ADD: alu_res = alua + alub;
      ALU_SUB: alu_res = alua - alub;
      ALU_AND: alu_res = alua & alub;
      ALU_OR:  alu_res = alua | alub;
      ALU_XOR: alu_res = alua ^ alub;
      ALU_LUI: alu_res = alub << 16;
      ALU_SLL: alu_res = alub << alua[SHW-1:0];
      ALU_SRL: alu_res = alub >> alua[SHW-1:0];
      ALU_SRA: alu_res = $unsigned($signed(alub) >>> alua[SHW-1:0]);
      default: alu_res = alua + alub;
    endcase
  end

  generate
    if (MD_EN != 0) begin : g_md
      logic       md_busy;
      logic [1:0] md_state;

      md_iter #(.XLEN(XLEN)) u_md (
        .clock  (clock),
        .reset  (reset),
        .start  (md_start),
        .flush  (eflush),
        .op     (emd_op),
        .a      (alua),
        .b      (alub),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result),
        .state  (md_state)
      );

      assign estall = ~eflush & (md_busy | ((md_state == MD_IDLE) & md_start));
    end else begin : g_no_md
      assign md_done   = 1'b0;
      assign md_result = '0;
      assign estall    = 1'b0;
    end
  endgenerate

  assign ealu = ejal ? epc8 : (md_done ? md_result : alu_res);
  assign ern  = ejal ? {REGW{1'b1}} : ern0;
  assign z    = (alu_res == '0);

  assign ex_is_uncond = ex_valid & ~eflush & ~estall & ej;
  assign ex_is_cond   = ex_valid & ~eflush & ~estall & ((z & ebeq) | (~z & ebne));

endmodule

// File: tb/tb_pipeexe_md.sv
// Directed bench for the execute stage: a driver pushes the expected
// {ealu, ern, z, uncond, cond} for each instruction and a negedge monitor
// compares whenever an instruction leaves EX.
module tb_pipeexe_md;
  import pipe_pkg::*;

  localparam int XLEN  = 32;
  localparam int REGW  = 5;
  localparam int ALUCW = 5;
  localparam int W     = XLEN + REGW + 3;

  logic             clock = 1'b0;
  logic             reset;
  logic             ex_valid, eflush;
  logic [XLEN-1:0]  ea, eb, eimm, epc4, malu, wdi;
  logic [REGW-1:0]  ern0;
  logic [ALUCW-1:0] ealuc;
  logic [1:0]       eadepen, ebdepen, emd_op;
  logic             ejal, ej, ebeq, ebne, emd_en;
  logic [XLEN-1:0]  ealu;
  logic [REGW-1:0]  ern;
  logic             z, ex_is_uncond, ex_is_cond, estall;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] mon_e;
  string        mon_nm;

  // Clock and watchdog.
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  pipeexe_md #(.XLEN(XLEN), .REGW(REGW), .ALUCW(ALUCW), .MD_EN(1)) dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .eflush(eflush),
    .ea(ea), .eb(eb), .eimm(eimm), .epc4(epc4), .ern0(ern0), .ealuc(ealuc),
    .eadepen(eadepen), .ebdepen(ebdepen), .malu(malu), .wdi(wdi),
    .ejal(ejal), .ej(ej), .ebeq(ebeq), .ebne(ebne), .emd_en(emd_en),
    .emd_op(emd_op), .ealu(ealu), .ern(ern), .z(z),
    .ex_is_uncond(ex_is_uncond), .ex_is_cond(ex_is_cond), .estall(estall)
  );

  function automatic logic [W-1:0] pack(input logic [XLEN-1:0] r, input logic [REGW-1:0] rn,
                                        input logic zz, input logic u, input logic c);
    return {r, rn, zz, u, c};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: an instruction leaves EX when live, unstalled, unflushed.
  always @(negedge clock) begin
    if (!reset && ex_valid && !estall && !eflush) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got ealu 0x%0h, expected no output", ealu);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_nm = name_q.pop_front();
        check(mon_nm, {ealu, ern, z, ex_is_uncond, ex_is_cond}, mon_e);
      end
    end
  end

  task automatic clear_in();
    ex_valid = 1'b1; eflush = 1'b0;
    ea = '0; eb = '0; eimm = '0; epc4 = '0; malu = '0; wdi = '0;
    ern0 = 5'd4; ealuc = ALU_ADD; eadepen = FWD_REG; ebdepen = FWD_REG;
    ejal = 1'b0; ej = 1'b0; ebeq = 1'b0; ebne = 1'b0;
    emd_en = 1'b0; emd_op = MD_MULLO;
  endtask

  // Issue the currently driven instruction and wait for it to leave EX.
  task automatic run_instr(input string nm, input logic [W-1:0] e, input int exp_stall,
                           input bit scramble);
    int n;
    bit gate_bad;
    n = 0;
    gate_bad = 1'b0;
    exp_q.push_back(e);
    name_q.push_back(nm);
    while (1) begin
      @(negedge clock);
      if (!estall) break;
      n++;
      if (ex_is_cond || ex_is_uncond) gate_bad = 1'b1;
      if (scramble && n == 2) begin
        malu = 32'h5;
        eb   = 32'h3;
      end
      if (n > 200) break;
    end
    check({nm, "_stall_cycles"}, n, exp_stall);
    check({nm, "_redirect_gated"}, gate_bad, 0);
    @(posedge clock); #1;
  endtask

  initial begin
    reset = 1'b1;
    clear_in();
    ex_valid = 1'b0;
    ea = 32'h5; eb = 32'h7;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_estall", estall, 0);
    check("reset_ealu", ealu, 32'hC);
    check("reset_ern", ern, 4);
    @(posedge clock); #1;

    clear_in(); ea = 32'h1; eb = 32'h2; malu = 32'h10; wdi = 32'h20;
    eadepen = FWD_MALU; ebdepen = FWD_WDI;
    run_instr("forward", pack(32'h30, 4, 0, 0, 0), 0, 0);

    clear_in(); ejal = 1'b1; ej = 1'b1; epc4 = 32'h100; ern0 = 5'd3;
    run_instr("jal", pack(32'h104, 31, 1, 1, 0), 0, 0);

    clear_in(); ea = 32'h1; eb = 32'h2; ej = 1'b1;
    run_instr("j", pack(32'h3, 4, 0, 1, 0), 0, 0);

    clear_in(); ea = 32'h9; eb = 32'h9; ealuc = ALU_SUB; ebeq = 1'b1;
    run_instr("beq_taken", pack(32'h0, 4, 1, 0, 1), 0, 0);

    clear_in(); eadepen = FWD_IMM; eimm = 32'hFFFF_FFE5; eb = 32'h3; ealuc = ALU_SLL; ebne = 1'b1;
    run_instr("sll_sa_bne", pack(32'h60, 4, 0, 0, 1), 0, 0);

    clear_in(); ea = 32'h10; ebdepen = FWD_IMM; eimm = 32'hFFFF_FFF0; ebne = 1'b1;
    run_instr("imm_bne_not", pack(32'h0, 4, 1, 0, 0), 0, 0);

    clear_in(); ea = 32'hFFFF_FFFF; eb = 32'h2; ealuc = ALU_OR; emd_en = 1'b1; emd_op = MD_MULHI;
    run_instr("mulhi", pack(32'h1, 4, 0, 0, 0), 33, 0);

    clear_in(); ea = 32'hFFFF_FFFF; eb = 32'h2; ealuc = ALU_OR; emd_en = 1'b1; emd_op = MD_MULLO;
    run_instr("mullo", pack(32'hFFFF_FFFE, 4, 0, 0, 0), 33, 0);

    clear_in(); eadepen = FWD_MALU; malu = 32'h10001; eb = 32'h10001; ealuc = ALU_AND;
    emd_en = 1'b1; emd_op = MD_MULLO;
    run_instr("mullo_capture", pack(32'h0002_0001, 4, 0, 0, 0), 33, 1);

    clear_in(); ea = 32'h1234; eb = 32'h0; ealuc = ALU_SUB; ebne = 1'b1; emd_en = 1'b1; emd_op = MD_DIVU;
    run_instr("divu_zero", pack(32'hFFFF_FFFF, 4, 0, 0, 1), 33, 0);

    clear_in(); ea = 32'h1234; eb = 32'h0; ealuc = ALU_SUB; ebne = 1'b1; emd_en = 1'b1; emd_op = MD_REMU;
    run_instr("remu_zero", pack(32'h1234, 4, 0, 0, 1), 33, 0);

    clear_in(); ea = 32'd100; eb = 32'd7; emd_en = 1'b1; emd_op = MD_DIVU;
    run_instr("divu_100_7", pack(32'd14, 4, 0, 0, 0), 33, 0);

    clear_in(); ea = 32'd100; eb = 32'd7; emd_en = 1'b1; emd_op = MD_REMU;
    run_instr("remu_100_7", pack(32'd2, 4, 0, 0, 0), 33, 0);

    // Flush at iteration 10 of a divide.
    clear_in(); ea = 32'h1234; eb = 32'h3; emd_en = 1'b1; emd_op = MD_DIVU;
    @(negedge clock);
    check("md_start_stall", estall, 1);
    repeat (11) @(posedge clock);
    #1 eflush = 1'b1;
    @(negedge clock);
    check("flush_stall", estall, 0);
    @(posedge clock); #1;
    clear_in(); ea = 32'h40; eb = 32'h2;
    run_instr("after_flush", pack(32'h42, 4, 0, 0, 0), 0, 0);

    // Flush together with a start condition: no start.
    clear_in(); ea = 32'h3; eb = 32'h3; emd_en = 1'b1; eflush = 1'b1;
    @(negedge clock);
    check("flush_start_stall", estall, 0);
    @(posedge clock); #1;
    clear_in(); ea = 32'h5; eb = 32'h6; ealuc = ALU_XOR;
    run_instr("after_flush_start", pack(32'h3, 4, 0, 0, 0), 0, 0);

    // Reset at iteration 5, then a taken beq.
    clear_in(); ea = 32'd100; eb = 32'd7; emd_en = 1'b1; emd_op = MD_DIVU;
    repeat (6) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    clear_in(); ea = 32'h77; eb = 32'h77; ealuc = ALU_SUB; ebeq = 1'b1;
    run_instr("after_reset", pack(32'h0, 4, 1, 0, 1), 0, 0);

    ex_valid = 1'b0;
    repeat (3) @(posedge clock);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
